// File: rtl/hilo_ctrl_if.sv
// Bundle of the control-unit, multiplier and divider signals seen by hilo_ctrl.
// The slave modport is the hilo_ctrl view; master is the environment's view.
interface hilo_ctrl_if #(
    parameter int WIDTH = 32
);
    // Control unit side
    logic             Start;
    logic             OpDiv;
    logic             HIWrite;
    logic             LOWrite;
    logic [WIDTH-1:0] WriteData;
    logic             Busy;
    logic             Done;
    logic             DivZeroExc;
    logic [WIDTH-1:0] HIOut;
    logic [WIDTH-1:0] LOOut;

    // Multiplier side
    logic             MultCtrl;
    logic             MultDone;
    logic [WIDTH-1:0] MultHIOut;
    logic [WIDTH-1:0] MultLOOut;

    // Divider side
    logic             DivCtrl;
    logic             DivDone;
    logic             Div0;
    logic [WIDTH-1:0] DivHIOut;
    logic [WIDTH-1:0] DivLOOut;

    modport slave (
        input  Start, OpDiv, HIWrite, LOWrite, WriteData,
        input  MultDone, MultHIOut, MultLOOut,
        input  DivDone, Div0, DivHIOut, DivLOOut,
        output MultCtrl, DivCtrl, HIOut, LOOut, Busy, Done, DivZeroExc
    );

    modport master (
        output Start, OpDiv, HIWrite, LOWrite, WriteData,
        output MultDone, MultHIOut, MultLOOut,
        output DivDone, Div0, DivHIOut, DivLOOut,
        input  MultCtrl, DivCtrl, HIOut, LOOut, Busy, Done, DivZeroExc
    );
endinterface

// File: rtl/hilo_ctrl.sv
// Launches an iterative multiply/divide, holds the unit enable for the whole
// operation and captures the unit's result into the architectural HI/LO.
module hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    hilo_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_op_div;
    logic             r_mult_ctrl;
    logic             r_div_ctrl;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero_exc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_op_div;
    logic             w_mult_ctrl;
    logic             w_div_ctrl;
    logic             w_done;
    logic             w_div_zero_exc;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    logic             w_unit_done;
    logic [WIDTH-1:0] w_unit_hi;
    logic [WIDTH-1:0] w_unit_lo;

    // Only the unit chosen at launch is ever looked at; the other is don't-care.
    assign w_unit_done = r_op_div ? bus.DivDone  : bus.MultDone;
    assign w_unit_hi   = r_op_div ? bus.DivHIOut : bus.MultHIOut;
    assign w_unit_lo   = r_op_div ? bus.DivLOOut : bus.MultLOOut;

    // NOTE: async active-low reset; every register has a defined reset value so
    // an enable drops the moment reset is asserted, without waiting for a clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments for all state so every flop samples
            // the pre-edge values regardless of process ordering.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_next_state   = r_state;
        w_op_div       = r_op_div;
        w_mult_ctrl    = r_mult_ctrl;
        w_div_ctrl     = r_div_ctrl;
        w_done         = 1'b0;
        w_div_zero_exc = 1'b0;
        w_hi           = r_hi;
        w_lo           = r_lo;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.HIWrite) begin
                    w_hi = bus.WriteData;
                end
                if (bus.LOWrite) begin
                    w_lo = bus.WriteData;
                end
                if (bus.Start) begin
                    w_op_div     = bus.OpDiv;
                    w_mult_ctrl  = ~bus.OpDiv;
                    w_div_ctrl   = bus.OpDiv;
                    w_next_state = ST_LAUNCH;
                end
            end

            // The unit's done level is stale until it sees its enable on this edge.
            ST_LAUNCH: begin
                w_next_state = ST_WAIT;
            end

            ST_WAIT: begin
                if (w_unit_done) begin
                    w_mult_ctrl  = 1'b0;
                    w_div_ctrl   = 1'b0;
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                    if (r_op_div && bus.Div0) begin
                        w_div_zero_exc = 1'b1;
                    end else begin
                        w_hi = w_unit_hi;
                        w_lo = w_unit_lo;
                    end
                end
            end

            default: begin
                w_mult_ctrl  = 1'b0;
                w_div_ctrl   = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op_div       <= 1'b0;
            r_mult_ctrl    <= 1'b0;
            r_div_ctrl     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_div_zero_exc <= 1'b0;
            r_hi           <= '0;
            r_lo           <= '0;
        end else begin
            r_op_div       <= w_op_div;
            r_mult_ctrl    <= w_mult_ctrl;
            r_div_ctrl     <= w_div_ctrl;
            r_busy         <= (w_next_state != ST_IDLE);
            r_done         <= w_done;
            r_div_zero_exc <= w_div_zero_exc;
            r_hi           <= w_hi;
            r_lo           <= w_lo;
        end
    end

    assign bus.MultCtrl   = r_mult_ctrl;
    assign bus.DivCtrl    = r_div_ctrl;
    assign bus.Busy       = r_busy;
    assign bus.Done       = r_done;
    assign bus.DivZeroExc = r_div_zero_exc;
    assign bus.HIOut      = r_hi;
    assign bus.LOOut      = r_lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: a behavioural divider stub plus a hand-driven
// multiplier stub, with hand-computed expected HI/LO values.
module tb_hilo_ctrl;

    logic clock;
    logic reset;

    hilo_ctrl_if #(.WIDTH(32)) bus ();

    hilo_ctrl #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divider stub: initialises on the first edge it sees DivCtrl high, flags
    // Div0 at that edge, otherwise raises done three edges later (k = 4).
    logic signed [31:0] div_a = '0;
    logic signed [31:0] div_b = 32'sd1;
    logic               div_armed = 1'b0;
    logic [2:0]         div_cnt = '0;

    always @(posedge clock) begin
        if (!bus.DivCtrl) begin
            div_armed <= 1'b0;
        end else if (!div_armed) begin
            div_armed <= 1'b1;
            if (div_b == 0) begin
                bus.DivDone  <= 1'b1;
                bus.Div0     <= 1'b1;
                bus.DivHIOut <= 32'hDEAD_0001;
                bus.DivLOOut <= 32'hDEAD_0002;
                div_cnt      <= '0;
            end else begin
                bus.DivDone <= 1'b0;
                bus.Div0    <= 1'b0;
                div_cnt     <= 3'd3;
            end
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 3'd1;
            if (div_cnt == 3'd1) begin
                bus.DivDone  <= 1'b1;
                bus.DivHIOut <= div_a % div_b;
                bus.DivLOOut <= div_a / div_b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic op_div, input logic [31:0] a, input logic [31:0] b);
        div_a     = a;
        div_b     = b;
        bus.OpDiv = op_div;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    // Counts edges until Done, and cycles in which the selected enable was low.
    task automatic wait_done(input int max_cycles, output int n, output int ctrl_low);
        n        = 0;
        ctrl_low = 0;
        while (!bus.Done && n < max_cycles) begin
            if (!(bus.DivCtrl || bus.MultCtrl)) ctrl_low++;
            tick();
            n++;
        end
    endtask

    int n_cyc;
    int n_low;
    int n_done_seen;

    initial begin
        reset         = 1'b0;
        bus.Start     = 1'b0;
        bus.OpDiv     = 1'b0;
        bus.HIWrite   = 1'b0;
        bus.LOWrite   = 1'b0;
        bus.WriteData = '0;
        bus.MultDone  = 1'b0;
        bus.MultHIOut = '0;
        bus.MultLOOut = '0;

        repeat (2) @(posedge clock);
        #3;
        check("rst_hi",    bus.HIOut, 32'h0);
        check("rst_lo",    bus.LOOut, 32'h0);
        check("rst_busy",  {31'b0, bus.Busy}, 32'h0);
        check("rst_done",  {31'b0, bus.Done}, 32'h0);
        check("rst_ctrl",  {30'b0, bus.MultCtrl, bus.DivCtrl}, 32'h0);
        check("rst_exc",   {31'b0, bus.DivZeroExc}, 32'h0);
        reset = 1'b1;
        tick();

        // 7 / 3
        start_op(1'b1, 32'd7, 32'd3);
        check("div73_ctrl", {30'b0, bus.MultCtrl, bus.DivCtrl}, 32'h1);
        check("div73_busy", {31'b0, bus.Busy}, 32'h1);
        wait_done(20, n_cyc, n_low);
        check("div73_lat",  n_cyc, 5);
        check("div73_held", n_low, 0);
        check("div73_hi",   bus.HIOut, 32'h1);
        check("div73_lo",   bus.LOOut, 32'h2);
        check("div73_exc",  {31'b0, bus.DivZeroExc}, 32'h0);
        check("div73_idle", {29'b0, bus.Busy, bus.MultCtrl, bus.DivCtrl}, 32'h0);
        tick();
        check("div73_pulse", {31'b0, bus.Done}, 32'h0);

        // -7 / 3, then 8 / 2 launched from the Done cycle
        start_op(1'b1, 32'hFFFF_FFF9, 32'd3);
        wait_done(20, n_cyc, n_low);
        check("divn73_lat", n_cyc, 5);
        check("divn73_hi",  bus.HIOut, 32'hFFFF_FFFF);
        check("divn73_lo",  bus.LOOut, 32'hFFFF_FFFE);
        check("b2b_gap",    {31'b0, bus.DivCtrl}, 32'h0);
        start_op(1'b1, 32'd8, 32'd2);
        check("b2b_relaunch", {31'b0, bus.DivCtrl}, 32'h1);
        wait_done(20, n_cyc, n_low);
        check("div82_lat", n_cyc, 5);
        check("div82_hi",  bus.HIOut, 32'h0);
        check("div82_lo",  bus.LOOut, 32'h4);
        tick();

        // Preload via mthi/mtlo together, then 5 / 0
        bus.HIWrite   = 1'b1;
        bus.LOWrite   = 1'b1;
        bus.WriteData = 32'hAAAA_5555;
        tick();
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
        check("preload_hi", bus.HIOut, 32'hAAAA_5555);
        check("preload_lo", bus.LOOut, 32'hAAAA_5555);
        start_op(1'b1, 32'd5, 32'd0);
        check("div0_e0_done", {31'b0, bus.Done}, 32'h0);
        tick();
        check("div0_e1_done", {31'b0, bus.Done}, 32'h0);
        tick();
        check("div0_e2_done", {31'b0, bus.Done}, 32'h1);
        check("div0_exc",     {31'b0, bus.DivZeroExc}, 32'h1);
        check("div0_hi",      bus.HIOut, 32'hAAAA_5555);
        check("div0_lo",      bus.LOOut, 32'hAAAA_5555);
        tick();
        check("div0_pulse", {30'b0, bus.Done, bus.DivZeroExc}, 32'h0);

        // Multiply with a stale done at launch (divider done/Div0 also stale high)
        bus.MultDone  = 1'b1;
        bus.MultHIOut = 32'h1111_1111;
        bus.MultLOOut = 32'h2222_2222;
        start_op(1'b0, 32'd0, 32'd1);
        check("mul_ctrl", {30'b0, bus.MultCtrl, bus.DivCtrl}, 32'h2);
        tick();
        check("mul_stale_done", {31'b0, bus.Done}, 32'h0);
        check("mul_stale_hi",   bus.HIOut, 32'hAAAA_5555);
        bus.MultDone = 1'b0;
        tick();
        tick();
        check("mul_wait", {30'b0, bus.Done, bus.Busy}, 32'h1);
        bus.MultDone  = 1'b1;
        bus.MultHIOut = 32'hFFFF_FFFF;
        bus.MultLOOut = 32'hFFFF_FFF4;
        tick();
        check("mul_done", {31'b0, bus.Done}, 32'h1);
        check("mul_hi",   bus.HIOut, 32'hFFFF_FFFF);
        check("mul_lo",   bus.LOOut, 32'hFFFF_FFF4);
        check("mul_exc",  {31'b0, bus.DivZeroExc}, 32'h0);
        tick();

        // Start / mthi / mtlo while busy are ignored; 100 / 7
        start_op(1'b1, 32'd100, 32'd7);
        bus.Start     = 1'b1;
        bus.OpDiv     = 1'b0;
        bus.HIWrite   = 1'b1;
        bus.LOWrite   = 1'b1;
        bus.WriteData = 32'hDEAD_BEEF;
        tick();
        bus.Start   = 1'b0;
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
        check("busy_wr_hi", bus.HIOut, 32'hFFFF_FFFF);
        check("busy_wr_lo", bus.LOOut, 32'hFFFF_FFF4);
        check("busy_start", {30'b0, bus.MultCtrl, bus.DivCtrl}, 32'h1);
        wait_done(20, n_cyc, n_low);
        check("div1007_lat", n_cyc, 4);
        check("div1007_hi",  bus.HIOut, 32'd2);
        check("div1007_lo",  bus.LOOut, 32'd14);
        tick();
        check("busy_no_relaunch", {29'b0, bus.Busy, bus.MultCtrl, bus.DivCtrl}, 32'h0);

        // mthi alone in IDLE
        bus.HIWrite   = 1'b1;
        bus.WriteData = 32'h1234_5678;
        tick();
        bus.HIWrite = 1'b0;
        check("mthi_hi", bus.HIOut, 32'h1234_5678);
        check("mthi_lo", bus.LOOut, 32'd14);

        // Start and mthi on the same IDLE edge
        bus.HIWrite   = 1'b1;
        bus.WriteData = 32'h0BAD_F00D;
        start_op(1'b1, 32'd8, 32'd2);
        bus.HIWrite = 1'b0;
        check("start_wr_hi",   bus.HIOut, 32'h0BAD_F00D);
        check("start_wr_busy", {31'b0, bus.Busy}, 32'h1);
        wait_done(20, n_cyc, n_low);
        check("start_wr_hi2", bus.HIOut, 32'h0);
        check("start_wr_lo2", bus.LOOut, 32'h4);
        tick();

        // Asynchronous reset mid-divide
        start_op(1'b1, 32'd7, 32'd3);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_ctrl", {30'b0, bus.MultCtrl, bus.DivCtrl}, 32'h0);
        check("arst_busy", {31'b0, bus.Busy}, 32'h0);
        check("arst_hi",   bus.HIOut, 32'h0);
        check("arst_lo",   bus.LOOut, 32'h0);
        n_done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.Done) n_done_seen++;
        end
        check("arst_no_done", n_done_seen, 0);
        #3;
        reset = 1'b1;
        tick();
        start_op(1'b1, 32'd8, 32'd2);
        wait_done(20, n_cyc, n_low);
        check("post_rst_lat", n_cyc, 5);
        check("post_rst_hi",  bus.HIOut, 32'h0);
        check("post_rst_lo",  bus.LOOut, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
